// File: rtl/exa_crosb_output_arbiter_vc.sv
// Per-output crossbar arbiter: class priority, then round-robin over (input, VC) within the class.
// The grant is held until tlast, and per-VC packet credits are kept. `ARB_WATCHDOG_EN adds a forced-release watchdog.
module exa_crosb_output_arbiter_vc #(
  parameter int input_num  = 8,
  parameter int prio_num   = 2,
  parameter int vc_num     = 3,
  parameter int fifo_depth = 4
`ifdef ARB_WATCHDOG_EN
  ,
  parameter int wd_cycles  = 64
`endif
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic [input_num-1:0][prio_num*vc_num-1:0]     i_request,
  input  logic [input_num-1:0]                          i_last,
  input  logic [prio_num*vc_num-1:0]                    i_credit_return,
  output logic [input_num-1:0][prio_num*vc_num-1:0]     o_grant,
  output logic [prio_num*vc_num-1:0]                    o_credits,
  output logic                                          o_busy,
  output logic [$clog2(input_num)-1:0]                  o_grant_input,
  output logic [$clog2(prio_num*vc_num)-1:0]            o_grant_vc
`ifdef ARB_WATCHDOG_EN
  ,
  output logic                                          o_timeout
`endif
);

  localparam int VCS = prio_num * vc_num;
  localparam int IW  = $clog2(input_num);
  localparam int VW  = $clog2(VCS);
  localparam int N   = input_num * vc_num;
  localparam int PW  = $clog2(N);
  localparam int CW  = $clog2(fifo_depth + 1);

  // Handshake: a request is a level; the grant rises one cycle after arbitration and stays
  // until the granted input's i_last pulse, which drops it on that same clock edge.
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    gin_q, gin_d;
  logic [VW-1:0]    gvc_q, gvc_d;
  logic [PW-1:0]    ptr_q [prio_num];
  logic [PW-1:0]    ptr_d [prio_num];
  logic [CW-1:0]    credit_q [VCS];
  logic [CW-1:0]    credit_d [VCS];

  logic [input_num-1:0][VCS-1:0] elig;
  logic [prio_num-1:0]           class_any;
  logic                          any_elig;
  logic                          win_found;
  int                            win_p, win_k, scan_k, cnt;
  logic                          grant_fire;
  logic                          restore;

`ifdef ARB_WATCHDOG_EN
  localparam int WDW = $clog2(wd_cycles + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;
`endif

  // Eligibility, winning class and round-robin scan from that class's pointer.
  always_comb begin
    elig      = '0;
    class_any = '0;
    win_p     = 0;
    win_k     = 0;
    scan_k    = 0;
    win_found = 1'b0;
    for (int i = 0; i < input_num; i++) begin
      for (int v = 0; v < VCS; v++) begin
        if (i_request[i][v] && (credit_q[v] != '0)) begin
          elig[i][v]             = 1'b1;
          class_any[v / vc_num]  = 1'b1;
        end
      end
    end
    any_elig = |class_any;
    for (int p = 0; p < prio_num; p++) begin
      if (class_any[p]) win_p = p;
    end
    for (int off = 0; off < N; off++) begin
      scan_k = (int'(ptr_q[win_p]) + off) % N;
      if (!win_found && elig[scan_k / vc_num][win_p * vc_num + scan_k % vc_num]) begin
        win_found = 1'b1;
        win_k     = scan_k;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gin_d      = gin_q;
    gvc_d      = gvc_q;
    ptr_d      = ptr_q;
    grant_fire = 1'b0;
    restore    = 1'b0;
    cnt        = 0;
`ifdef ARB_WATCHDOG_EN
    wd_d       = wd_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          grant_fire   = 1'b1;
          state_d      = S_BUSY;
          gin_d        = IW'(win_k / vc_num);
          gvc_d        = VW'(win_p * vc_num + win_k % vc_num);
          ptr_d[win_p] = PW'((win_k + 1) % N);
`ifdef ARB_WATCHDOG_EN
          wd_d         = '0;
`endif
        end
      end
      S_BUSY: begin
        if (i_last[gin_q]) begin
          state_d = S_IDLE;
`ifdef ARB_WATCHDOG_EN
          wd_d    = '0;
        end else if (wd_q == WDW'(wd_cycles - 1)) begin
          // Stuck packet: release and give back the credit the grant consumed.
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          restore   = 1'b1;
          wd_d      = '0;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Returns beyond fifo_depth are protocol errors and saturate.
    for (int v = 0; v < VCS; v++) begin
      cnt = int'(credit_q[v]);
      if (grant_fire && (int'(gvc_d) == v)) cnt = cnt - 1;
      if (i_credit_return[v]) cnt = cnt + 1;
      if (restore && (int'(gvc_q) == v)) cnt = cnt + 1;
      if (cnt > fifo_depth) cnt = fifo_depth;
      credit_d[v] = CW'(cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      gin_q   <= '0;
      gvc_q   <= '0;
      for (int p = 0; p < prio_num; p++) ptr_q[p] <= '0;
      for (int v = 0; v < VCS; v++) credit_q[v] <= CW'(fifo_depth);
`ifdef ARB_WATCHDOG_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gin_q    <= gin_d;
      gvc_q    <= gvc_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
`ifdef ARB_WATCHDOG_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    o_grant = '0;
    if (state_q == S_BUSY) o_grant[gin_q][gvc_q] = 1'b1;
    for (int v = 0; v < VCS; v++) o_credits[v] = (credit_q[v] != '0);
  end

  assign o_busy        = (state_q == S_BUSY);
  assign o_grant_input = gin_q;
  assign o_grant_vc    = gvc_q;
`ifdef ARB_WATCHDOG_EN
  assign o_timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_exa_crosb_output_arbiter_vc.sv
// Bench for exa_crosb_output_arbiter_vc: directed step table, then random traffic against a queue-based model.
module tb_exa_crosb_output_arbiter_vc;

  localparam int NI  = 8;
  localparam int NV  = 6;
  localparam int VPC = 3;
  localparam int NK  = NI * VPC;
  localparam int FD  = 4;
  localparam int W   = 61;

  logic                   clk;
  logic                   resetn;
  logic [NI-1:0][NV-1:0]  i_request;
  logic [NI-1:0]          i_last;
  logic [NV-1:0]          i_credit_return;
  logic [NI-1:0][NV-1:0]  o_grant;
  logic [NV-1:0]          o_credits;
  logic                   o_busy;
  logic [2:0]             o_grant_input;
  logic [2:0]             o_grant_vc;

  exa_crosb_output_arbiter_vc dut (
    .clk             (clk),
    .resetn          (resetn),
    .i_request       (i_request),
    .i_last          (i_last),
    .i_credit_return (i_credit_return),
    .o_grant         (o_grant),
    .o_credits       (o_credits),
    .o_busy          (o_busy),
    .o_grant_input   (o_grant_input),
    .o_grant_vc      (o_grant_vc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        rst;
    logic [47:0] req;
    logic [7:0]  last;
    logic [5:0]  ret;
    logic        busy;
    int          gin;
    int          gvc;
    logic [5:0]  cred;
  } vec_t;

  vec_t tbl[$];
  logic [W-1:0] exp_q[$];

  // Model state
  logic m_busy;
  int   m_gin, m_gvc;
  int   m_cred[NV];
  int   m_ptr[2];

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
  endtask

  function automatic logic [47:0] r1(input int i, input int v);
    logic [47:0] r;
    r = '0;
    r[i*NV+v] = 1'b1;
    return r;
  endfunction

  task automatic add(input logic rst, input logic [47:0] req, input logic [7:0] last, input logic [5:0] ret,
                     input logic busy, input int gin, input int gvc, input logic [5:0] cred);
    vec_t t;
    t.rst = rst; t.req = req; t.last = last; t.ret = ret;
    t.busy = busy; t.gin = gin; t.gvc = gvc; t.cred = cred;
    tbl.push_back(t);
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [47:0] eg;
    resetn          = !t.rst;
    i_request       = t.req;
    i_last          = t.last;
    i_credit_return = t.ret;
    @(posedge clk);
    #1;
    eg = '0;
    if (t.busy) eg[t.gin*NV+t.gvc] = 1'b1;
    chk("busy", idx, 64'(o_busy), 64'(t.busy));
    chk("credits", idx, 64'(o_credits), 64'(t.cred));
    chk("grant", idx, 64'(o_grant), 64'(eg));
    if (t.busy) begin
      chk("grant_input", idx, 64'(o_grant_input), 64'(t.gin));
      chk("grant_vc", idx, 64'(o_grant_vc), 64'(t.gvc));
    end
    if (t.rst) begin
      chk("rst_grant_input", idx, 64'(o_grant_input), 64'd0);
      chk("rst_grant_vc", idx, 64'(o_grant_vc), 64'd0);
    end
  endtask

  // Reference: highest class with any eligible pair; within it, the eligible flat index
  // nearest at-or-after the class pointer (circular distance) wins.
  task automatic model_step(input logic rst, input logic [47:0] req, input logic [7:0] last, input logic [5:0] ret);
    int          kq[$];
    int          dec[NV];
    int          best, bestd, d, v, c;
    logic        found;
    logic [47:0] g;
    logic [5:0]  cb;
    if (rst) begin
      m_busy = 1'b0; m_gin = 0; m_gvc = 0;
      for (int i = 0; i < NV; i++) m_cred[i] = FD;
      m_ptr[0] = 0; m_ptr[1] = 0;
    end else begin
      for (int i = 0; i < NV; i++) dec[i] = 0;
      found = 1'b0;
      if (!m_busy) begin
        for (int p = 1; p >= 0; p--) begin
          if (!found) begin
            kq.delete();
            for (int k = 0; k < NK; k++) begin
              v = p*VPC + k%VPC;
              if (req[(k/VPC)*NV+v] && m_cred[v] > 0) kq.push_back(k);
            end
            if (kq.size() > 0) begin
              best = kq[0]; bestd = NK;
              foreach (kq[j]) begin
                d = (kq[j] - m_ptr[p] + NK) % NK;
                if (d < bestd) begin bestd = d; best = kq[j]; end
              end
              found    = 1'b1;
              m_busy   = 1'b1;
              m_gin    = best / VPC;
              m_gvc    = p*VPC + best % VPC;
              m_ptr[p] = (best + 1) % NK;
              dec[m_gvc] = 1;
            end
          end
        end
      end else if (last[m_gin]) begin
        m_busy = 1'b0;
      end
      for (int i = 0; i < NV; i++) begin
        c = m_cred[i] - dec[i] + int'(ret[i]);
        m_cred[i] = (c > FD) ? FD : c;
      end
    end
    g = '0;
    if (m_busy) g[m_gin*NV+m_gvc] = 1'b1;
    for (int i = 0; i < NV; i++) cb[i] = (m_cred[i] > 0);
    exp_q.push_back({m_busy, 3'(m_gin), 3'(m_gvc), cb, g});
  endtask

  initial begin
    logic [47:0]  r05, r3;
    logic [47:0]  req;
    logic [7:0]   last;
    logic [5:0]   ret;
    logic         rst;
    logic [W-1:0] e;

    resetn = 1'b0; i_request = '0; i_last = '0; i_credit_return = '0;

    // Reset and idle
    add(1, '0, 8'h00, 6'h00, 0, 0, 0, 6'h3f);
    add(0, '0, 8'h00, 6'h00, 0, 0, 0, 6'h3f);
    // Single low-class request, held 17 cycles with request withdrawn, foreign last ignored
    add(0, r1(2,1), 8'h00, 6'h00, 1, 2, 1, 6'h3f);
    for (int j = 0; j < 16; j++)
      add(0, '0, (j == 5) ? 8'h20 : 8'h00, 6'h00, 1, 2, 1, 6'h3f);
    add(0, '0, 8'h04, 6'h00, 0, 0, 0, 6'h3f);
    // Class priority and round-robin on VC0 until credit exhaustion
    r05 = r1(0,0) | r1(5,0);
    r3  = r05 | r1(3,4);
    add(1, '0, 8'h00, 6'h00, 0, 0, 0, 6'h3f);
    add(0, r3,  8'h00, 6'h00, 1, 3, 4, 6'h3f);
    add(0, r3,  8'h00, 6'h00, 1, 3, 4, 6'h3f);
    add(0, r3,  8'h08, 6'h00, 0, 0, 0, 6'h3f);
    add(0, r05, 8'h00, 6'h00, 1, 0, 0, 6'h3f);
    add(0, r05, 8'h01, 6'h00, 0, 0, 0, 6'h3f);
    add(0, r05, 8'h00, 6'h00, 1, 5, 0, 6'h3f);
    add(0, r05, 8'h20, 6'h00, 0, 0, 0, 6'h3f);
    add(0, r05, 8'h00, 6'h00, 1, 0, 0, 6'h3f);
    add(0, r05, 8'h01, 6'h00, 0, 0, 0, 6'h3f);
    add(0, r05, 8'h00, 6'h00, 1, 5, 0, 6'h3e);
    add(0, r05, 8'h20, 6'h00, 0, 0, 0, 6'h3e);
    add(0, r05, 8'h00, 6'h00, 0, 0, 0, 6'h3e);
    add(0, r05, 8'h00, 6'h01, 0, 0, 0, 6'h3f);
    add(0, r05, 8'h00, 6'h00, 1, 0, 0, 6'h3e);
    add(0, '0,  8'h01, 6'h00, 0, 0, 0, 6'h3e);
    // Drain VC2, blocked request, then a single return unblocks it
    add(1, '0, 8'h00, 6'h00, 0, 0, 0, 6'h3f);
    for (int j = 0; j < 4; j++) begin
      add(0, r1(1,2), 8'h00, 6'h00, 1, 1, 2, (j == 3) ? 6'h3b : 6'h3f);
      add(0, '0, 8'h02, 6'h00, 0, 0, 0, (j == 3) ? 6'h3b : 6'h3f);
    end
    add(0, r1(1,2), 8'h00, 6'h00, 0, 0, 0, 6'h3b);
    add(0, r1(1,2), 8'h00, 6'h04, 0, 0, 0, 6'h3f);
    add(0, r1(1,2), 8'h00, 6'h00, 1, 1, 2, 6'h3b);
    add(0, '0, 8'h02, 6'h00, 0, 0, 0, 6'h3b);
    // VC3 down to one credit, then grant and return in the same cycle, then reset mid-packet
    add(1, '0, 8'h00, 6'h00, 0, 0, 0, 6'h3f);
    for (int j = 0; j < 3; j++) begin
      add(0, r1(6,3), 8'h00, 6'h00, 1, 6, 3, 6'h3f);
      add(0, '0, 8'h40, 6'h00, 0, 0, 0, 6'h3f);
    end
    add(0, r1(6,3), 8'h00, 6'h08, 1, 6, 3, 6'h3f);
    add(0, '0, 8'h00, 6'h00, 1, 6, 3, 6'h3f);
    add(1, '0, 8'h00, 6'h00, 0, 0, 0, 6'h3f);
    add(0, '0, 8'h00, 6'h00, 0, 0, 0, 6'h3f);

    for (int s = 0; s < tbl.size(); s++) apply(tbl[s], s);

    // Randomized traffic against the model
    rst = 1'b1;
    model_step(1'b1, '0, '0, '0);
    void'(exp_q.pop_front());
    resetn = 1'b0; i_request = '0; i_last = '0; i_credit_return = '0;
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      req = '0;
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 2) == 0) req[i*NV + $urandom_range(0, NV-1)] = 1'b1;
        if ($urandom_range(0, 7) == 0) req[i*NV + $urandom_range(0, NV-1)] = 1'b1;
      end
      last = '0;
      if (m_busy && $urandom_range(0, 4) == 0) last[m_gin] = 1'b1;
      for (int i = 0; i < NI; i++) if ($urandom_range(0, 15) == 0) last[i] = 1'b1;
      ret = '0;
      for (int v = 0; v < NV; v++) if ($urandom_range(0, 6) == 0) ret[v] = 1'b1;
      model_step(rst, req, last, ret);
      resetn = !rst; i_request = req; i_last = last; i_credit_return = ret;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("rnd_busy", c, 64'(o_busy), 64'(e[60]));
      chk("rnd_credits", c, 64'(o_credits), 64'(e[53:48]));
      chk("rnd_grant", c, 64'(o_grant), 64'(e[47:0]));
      if (e[60]) begin
        chk("rnd_grant_input", c, 64'(o_grant_input), 64'(e[59:57]));
        chk("rnd_grant_vc", c, 64'(o_grant_vc), 64'(e[56:54]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
